spi_bus_arbiter: RTL and testbench
==================================

// Module: spi_bus_arbiter
// PURPOSE
//  Shares one simple SPI master among NUM_REQ system-side requesters. Arbitrates round-robin,
//  sequences the master's start/complete cycle, and routes its single chip-select to a
//  per-device select line. Returns read data and a completion/error pulse to the winner.
// PARAMETERS
//  NUM_REQ     4    number of requesters / SPI devices (2..8)
//  REG_WIDTH   8    SPI shift-register width; must match the master
//  CNT_W       $clog2(REG_WIDTH)+1  width of transfer-size fields
//  TIMEOUT     64   max cycles waited in WAIT_LO or WAIT_HI before aborting with err
// PORTS
//  sys_clk     in   1                  system clock
//  rst         in   1                  synchronous, active-low reset
//  req         in   NUM_REQ            per-requester request level, held until ack
//  req_data    in   NUM_REQ*REG_WIDTH  write data; requester i in slice [i*REG_WIDTH +: REG_WIDTH]
//  req_size    in   NUM_REQ*CNT_W      bit count; requester i in slice [i*CNT_W +: CNT_W]
//  ack         out  NUM_REQ            one-cycle completion pulse to the granted requester
//  err         out  1                  qualifies ack: 1 = rejected or timed out
//  rdata       out  REG_WIDTH          read data; valid only in the ack cycle
//  busy        out  1                  high in every state except IDLE
//  grant_id    out  $clog2(NUM_REQ)    index of the current/last winner
//  m_t_begin   out  1                  master start strobe
//  m_data_in   out  REG_WIDTH          master write data (latched copy)
//  m_t_size    out  CNT_W              master bit count (latched copy)
//  m_data_out  in   REG_WIDTH          master read data
//  m_cs        in   1                  master chip select, active low
//  dev_cs_n    out  NUM_REQ            per-device chip selects, active low
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, rr_ptr=0, ack=0, err=0, rdata=0, busy=0,
//   grant_id=0, m_t_begin=0, m_data_in=0, m_t_size=0, dev_cs_n=all 1s. Reset mid-transfer
//   aborts with no ack; the master is reset from the same rst.
//  Arbitration (IDLE only): winner = first i with req[i]==1 scanning rr_ptr, rr_ptr+1, ...
//   mod NUM_REQ. Winner's data/size latched into m_data_in/m_t_size; grant_id=winner.
//  FSM, one transition per sys_clk:
//   IDLE    - any req: size==0 or size>REG_WIDTH -> REJECT; else -> START. No req: stay.
//   START   - m_t_begin=1 for exactly this cycle -> WAIT_LO; timer cleared.
//   WAIT_LO - m_cs==0 -> WAIT_HI (timer cleared); timer==TIMEOUT-1 -> REJECT.
//   WAIT_HI - m_cs==1 -> DONE; timer==TIMEOUT-1 -> REJECT.
//   DONE    - rdata<=m_data_out, ack[grant_id]=1, err=0 -> IDLE.
//   REJECT  - rdata<=0, ack[grant_id]=1, err=1 -> IDLE; master never started (IDLE path)
//             or left to finish/reset on its own (timeout path).
//  rr_ptr <= grant_id+1 (mod NUM_REQ) on leaving DONE or REJECT; never changed otherwise.
//  Latency: req sampled in IDLE at cycle 0 -> m_t_begin high in cycle 1. Best-case ack
//   follows master's cs-high by 1 cycle. Back-to-back: next grant earliest the cycle after ack.
//  m_t_begin is 0 in all states except START, so the master returns to idle after unload.
//  dev_cs_n[i] = m_cs when state in {START,WAIT_LO,WAIT_HI} and grant_id==i, else 1.
//  Handshake: req deassert before grant = cancel. req change or deassert after grant is
//   ignored; the transfer runs to completion and ack is still pulsed. req held high past
//   ack re-enters arbitration as a new request at lowest priority.
//  req_data/req_size may change freely after grant (latched copies drive the master).
//  ack is one-hot or zero; err is 0 whenever ack==0.
// TESTING
//  1 req[2]=1, data=8'hA5, size=8, slave returns 8'h3C -> dev_cs_n[2] only low, ack[2] pulse, rdata=8'h3C, err=0.
//  2 req=4'b1111 held, rr_ptr=0 -> grants in order 0,1,2,3,0; each ack exactly one cycle.
//  3 req[1] size=0, then size=9 -> ack[1]+err=1 within 2 cycles, m_t_begin never asserted.
//  4 m_cs tied high after START -> ack+err exactly TIMEOUT cycles after WAIT_LO entry; next req served.
//  5 rst=0 during WAIT_HI -> next cycle all outputs at reset values, dev_cs_n=4'hF, no ack issued.
//  6 req[3] dropped one cycle after grant -> transfer completes, ack[3] still pulsed, rr_ptr=0.

Source files
------------

// File: rtl/spi_bus_arbiter.sv
// Round-robin arbiter that shares one SPI master among NUM_REQ requesters,
// sequences the master's start/complete handshake and routes its chip select.
module spi_bus_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int REG_WIDTH = 8,
  parameter int CNT_W     = $clog2(REG_WIDTH) + 1,
  parameter int TIMEOUT   = 64
) (
  input  logic                         sys_clk,
  input  logic                         rst,
  input  logic [NUM_REQ-1:0]           req,
  input  logic [NUM_REQ*REG_WIDTH-1:0] req_data,
  input  logic [NUM_REQ*CNT_W-1:0]     req_size,
  output logic [NUM_REQ-1:0]           ack,
  output logic                         err,
  output logic [REG_WIDTH-1:0]         rdata,
  output logic                         busy,
  output logic [$clog2(NUM_REQ)-1:0]   grant_id,
  output logic                         m_t_begin,
  output logic [REG_WIDTH-1:0]         m_data_in,
  output logic [CNT_W-1:0]             m_t_size,
  input  logic [REG_WIDTH-1:0]         m_data_out,
  input  logic                         m_cs,
  output logic [NUM_REQ-1:0]           dev_cs_n
);

  localparam int ID_W  = $clog2(NUM_REQ);
  localparam int SUM_W = ID_W + 1;
  localparam int TMR_W = $clog2(TIMEOUT + 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0  = NUM_REQ'(1);
  localparam logic [TMR_W-1:0]   TMR_LAST  = TMR_W'(TIMEOUT - 1);
  localparam logic [ID_W-1:0]    LAST_ID   = ID_W'(NUM_REQ - 1);
  localparam logic [CNT_W-1:0]   MAX_SIZE  = CNT_W'(REG_WIDTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    WAIT_LO,
    WAIT_HI,
    DONE,
    REJECT
  } state_t;

  state_t             state_reg;
  logic [ID_W-1:0]    rr_ptr_reg;
  logic [TMR_W-1:0]   timer_reg;

  logic [REG_WIDTH-1:0] data_arr [NUM_REQ];
  logic [CNT_W-1:0]     size_arr [NUM_REQ];
  logic [SUM_W-1:0]     scan_sum [NUM_REQ];
  logic [ID_W-1:0]      scan_idx [NUM_REQ];

  logic               win_valid;
  logic [ID_W-1:0]    win_idx;
  logic [CNT_W-1:0]   win_size;
  logic               win_bad;
  logic               cs_route;
  logic [ID_W-1:0]    next_ptr;

  // scan_idx[k] is the requester examined k-th, starting from the rr pointer
  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slot
      assign data_arr[gi] = req_data[gi*REG_WIDTH +: REG_WIDTH];
      assign size_arr[gi] = req_size[gi*CNT_W +: CNT_W];
      assign scan_sum[gi] = {1'b0, rr_ptr_reg} + SUM_W'(gi);
      assign scan_idx[gi] = (scan_sum[gi] >= SUM_W'(NUM_REQ))
                          ? ID_W'(scan_sum[gi] - SUM_W'(NUM_REQ))
                          : scan_sum[gi][ID_W-1:0];
    end
  endgenerate

  // Walk the scan order backwards so the requester closest to the pointer wins
  always_comb begin
    win_valid = 1'b0;
    win_idx   = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (req[scan_idx[k]]) begin
        win_valid = 1'b1;
        win_idx   = scan_idx[k];
      end
    end
  end

  assign win_size = size_arr[win_idx];
  assign win_bad  = (win_size == '0) || (win_size > MAX_SIZE);
  assign next_ptr = (grant_id == LAST_ID) ? '0 : grant_id + 1'b1;
  assign cs_route = (state_reg == START) || (state_reg == WAIT_LO) || (state_reg == WAIT_HI);

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_cs
      assign dev_cs_n[gi] = (cs_route && (grant_id == ID_W'(gi))) ? m_cs : 1'b1;
    end
  endgenerate

  always_ff @(posedge sys_clk) begin
    if (!rst) begin
      state_reg  <= IDLE;
      rr_ptr_reg <= '0;
      timer_reg  <= '0;
      ack        <= '0;
      err        <= 1'b0;
      rdata      <= '0;
      busy       <= 1'b0;
      grant_id   <= '0;
      m_t_begin  <= 1'b0;
      m_data_in  <= '0;
      m_t_size   <= '0;
    end else begin
      ack       <= '0;
      err       <= 1'b0;
      m_t_begin <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (win_valid) begin
            grant_id  <= win_idx;
            m_data_in <= data_arr[win_idx];
            m_t_size  <= win_size;
            busy      <= 1'b1;
            if (win_bad) begin
              state_reg <= REJECT;
              rdata     <= '0;
              ack       <= ONE_HOT0 << win_idx;
              err       <= 1'b1;
            end else begin
              state_reg <= START;
              m_t_begin <= 1'b1;
            end
          end
        end
        START: begin
          state_reg <= WAIT_LO;
          timer_reg <= '0;
        end
        WAIT_LO: begin
          if (!m_cs) begin
            state_reg <= WAIT_HI;
            timer_reg <= '0;
          end else if (timer_reg == TMR_LAST) begin
            state_reg <= REJECT;
            rdata     <= '0;
            ack       <= ONE_HOT0 << grant_id;
            err       <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        WAIT_HI: begin
          if (m_cs) begin
            state_reg <= DONE;
            rdata     <= m_data_out;
            ack       <= ONE_HOT0 << grant_id;
          end else if (timer_reg == TMR_LAST) begin
            // master is left to finish its frame on its own
            state_reg <= REJECT;
            rdata     <= '0;
            ack       <= ONE_HOT0 << grant_id;
            err       <= 1'b1;
          end else begin
            timer_reg <= timer_reg + 1'b1;
          end
        end
        DONE, REJECT: begin
          state_reg  <= IDLE;
          busy       <= 1'b0;
          rr_ptr_reg <= next_ptr;
        end
        default: begin
          state_reg <= IDLE;
          busy      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Self-checking bench for spi_bus_arbiter: vector table, hand-written corner
// sequences and randomized traffic against a round-robin reference model.
module tb_spi_bus_arbiter;

  localparam int NUM_REQ   = 4;
  localparam int REG_WIDTH = 8;
  localparam int CNT_W     = 4;
  localparam int TIMEOUT   = 64;

  logic                         sys_clk = 1'b0;
  logic                         rst;
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*REG_WIDTH-1:0] req_data;
  logic [NUM_REQ*CNT_W-1:0]     req_size;
  logic [NUM_REQ-1:0]           ack;
  logic                         err;
  logic [REG_WIDTH-1:0]         rdata;
  logic                         busy;
  logic [1:0]                   grant_id;
  logic                         m_t_begin;
  logic [REG_WIDTH-1:0]         m_data_in;
  logic [CNT_W-1:0]             m_t_size;
  logic [REG_WIDTH-1:0]         m_data_out;
  logic                         m_cs;
  logic [NUM_REQ-1:0]           dev_cs_n;

  spi_bus_arbiter #(
    .NUM_REQ(NUM_REQ), .REG_WIDTH(REG_WIDTH), .CNT_W(CNT_W), .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk(sys_clk), .rst(rst), .req(req), .req_data(req_data), .req_size(req_size),
    .ack(ack), .err(err), .rdata(rdata), .busy(busy), .grant_id(grant_id),
    .m_t_begin(m_t_begin), .m_data_in(m_data_in), .m_t_size(m_t_size),
    .m_data_out(m_data_out), .m_cs(m_cs), .dev_cs_n(dev_cs_n)
  );

  always #5 sys_clk = ~sys_clk;

  int checks = 0;
  int errors = 0;
  int begin_count = 0;
  logic [NUM_REQ-1:0] dev_low_seen;

  // SPI master stand-in: after seeing m_t_begin it waits lo_delay cycles,
  // holds cs low for cs_len cycles, then raises cs with slave_rdata on m_data_out
  int         lo_delay = 1;
  int         cs_len = 1;
  logic [7:0] slave_rdata = '0;
  bit         master_on = 1'b1;
  bit         master_busy;
  bit         m_abort;
  int         m_l;
  int         m_c;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    m_cs = 1'b1;
    m_data_out = '0;
    master_busy = 1'b0;
    forever begin
      @(posedge sys_clk);
      #2;
      if (rst && m_t_begin && master_on) begin
        master_busy = 1'b1;
        m_abort = 1'b0;
        m_l = lo_delay;
        m_c = cs_len;
        for (int k = 0; k < m_l && !m_abort; k++) begin
          @(posedge sys_clk);
          #2;
          if (!rst) m_abort = 1'b1;
        end
        if (!m_abort) m_cs = 1'b0;
        for (int k = 0; k < m_c && !m_abort; k++) begin
          @(posedge sys_clk);
          #2;
          if (!rst) m_abort = 1'b1;
        end
        if (!m_abort) m_data_out = slave_rdata;
        m_cs = 1'b1;
        master_busy = 1'b0;
      end
    end
  end

  // Cycle-by-cycle invariants on the outputs
  logic prev_begin = 1'b0;
  initial begin
    forever begin
      @(negedge sys_clk);
      if (m_t_begin) begin_count++;
      chk("ack_onehot0", 32'($onehot0(ack)), 32'd1);
      chk("err_qualified", 32'(err && (ack == '0)), 32'd0);
      chk("begin_single_cycle", 32'(prev_begin && m_t_begin), 32'd0);
      if (dev_cs_n != 4'hF)
        chk("dev_cs_route", {m_cs, busy, dev_cs_n}, {1'b0, 1'b1, ~(4'b0001 << grant_id)});
      prev_begin = m_t_begin;
    end
  end

  initial begin
    #1ms;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  function automatic int rr_pick(input logic [3:0] mask, input int ptr);
    for (int k = 0; k < NUM_REQ; k++)
      if (mask[(ptr + k) % NUM_REQ]) return (ptr + k) % NUM_REQ;
    return -1;
  endfunction

  task automatic set_slot(input int i, input logic [7:0] d, input logic [3:0] s);
    req_data[i*REG_WIDTH +: REG_WIDTH] = d;
    req_size[i*CNT_W +: CNT_W] = s;
  endtask

  // Returns at the negedge where ack is first seen; cyc counts negedges since the call
  task automatic wait_ack(input int budget, output int cyc);
    bit found;
    found = 1'b0;
    cyc = 0;
    while (cyc < budget && !found) begin
      @(negedge sys_clk);
      cyc++;
      dev_low_seen = dev_low_seen | ~dev_cs_n;
      if (ack != '0) found = 1'b1;
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL ack_timeout actual=no_ack required=ack_within_%0d", budget);
    end
  endtask

  task automatic clear_ack(input string name);
    @(negedge sys_clk);
    chk(name, 32'(ack), 32'd0);
  endtask

  task automatic wait_master_idle(input int budget);
    int n;
    n = 0;
    while (master_busy && n < budget) begin
      @(negedge sys_clk);
      n++;
    end
    chk("master_idle", 32'(master_busy), 32'd0);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_ack"}, 32'(ack), 32'd0);
    chk({tag, "_err"}, 32'(err), 32'd0);
    chk({tag, "_rdata"}, 32'(rdata), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_grant_id"}, 32'(grant_id), 32'd0);
    chk({tag, "_m_t_begin"}, 32'(m_t_begin), 32'd0);
    chk({tag, "_m_data_in"}, 32'(m_data_in), 32'd0);
    chk({tag, "_m_t_size"}, 32'(m_t_size), 32'd0);
    chk({tag, "_dev_cs_n"}, 32'(dev_cs_n), 32'hF);
  endtask

  task automatic do_reset();
    req = '0;
    rst = 1'b0;
    repeat (2) @(negedge sys_clk);
    rst = 1'b1;
    wait_master_idle(50);
  endtask

  typedef struct {
    int         id;
    logic [7:0] data;
    logic [3:0] size;
    logic [7:0] slave;
    int         lo;
    int         len;
    logic       exp_err;
    logic [7:0] exp_rdata;
    int         exp_cyc;
  } vec_t;

  vec_t       vecs[7];
  int         cyc;
  int         b0;
  int         acks_seen;
  int         model_ptr;
  int         exp_id;
  logic       exp_err;
  logic [3:0] pend;
  logic [3:0] new_mask;
  logic [7:0] d_arr[NUM_REQ];
  logic [3:0] s_arr[NUM_REQ];
  logic [7:0] rr_exp[5];

  initial begin
    // valid: ack lo+len+2 cycles after req is driven; rejected from IDLE: 1 cycle
    vecs[0] = '{2, 8'hA5, 4'd8,  8'h3C, 1, 8, 1'b0, 8'h3C, 11};
    vecs[1] = '{1, 8'h11, 4'd0,  8'hEE, 1, 1, 1'b1, 8'h00, 1};
    vecs[2] = '{1, 8'h55, 4'd9,  8'hEE, 1, 1, 1'b1, 8'h00, 1};
    vecs[3] = '{0, 8'h81, 4'd1,  8'hE7, 1, 1, 1'b0, 8'hE7, 4};
    vecs[4] = '{3, 8'hFF, 4'd15, 8'hEE, 1, 1, 1'b1, 8'h00, 1};
    vecs[5] = '{3, 8'h12, 4'd7,  8'h5A, 2, 7, 1'b0, 8'h5A, 11};
    vecs[6] = '{0, 8'hC3, 4'd4,  8'h00, 3, 2, 1'b0, 8'h00, 7};

    rst = 1'b0;
    req = '0;
    req_data = '0;
    req_size = '0;
    repeat (3) @(negedge sys_clk);
    check_reset_vals("reset");
    rst = 1'b1;

    for (int v = 0; v < 7; v++) begin
      set_slot(vecs[v].id, vecs[v].data, vecs[v].size);
      lo_delay = vecs[v].lo;
      cs_len = vecs[v].len;
      slave_rdata = vecs[v].slave;
      dev_low_seen = '0;
      b0 = begin_count;
      req[vecs[v].id] = 1'b1;
      wait_ack(200, cyc);
      chk($sformatf("vec%0d_ack", v), 32'(ack), 32'd1 << vecs[v].id);
      chk($sformatf("vec%0d_err", v), 32'(err), 32'(vecs[v].exp_err));
      chk($sformatf("vec%0d_rdata", v), 32'(rdata), 32'(vecs[v].exp_rdata));
      chk($sformatf("vec%0d_grant_id", v), 32'(grant_id), 32'(vecs[v].id));
      chk($sformatf("vec%0d_m_data_in", v), 32'(m_data_in), 32'(vecs[v].data));
      chk($sformatf("vec%0d_m_t_size", v), 32'(m_t_size), 32'(vecs[v].size));
      chk($sformatf("vec%0d_busy", v), 32'(busy), 32'd1);
      chk($sformatf("vec%0d_latency", v), 32'(cyc), 32'(vecs[v].exp_cyc));
      chk($sformatf("vec%0d_dev_cs_low", v), 32'(dev_low_seen),
          vecs[v].exp_err ? 32'd0 : (32'd1 << vecs[v].id));
      chk($sformatf("vec%0d_begins", v), 32'(begin_count - b0), vecs[v].exp_err ? 32'd0 : 32'd1);
      req[vecs[v].id] = 1'b0;
      clear_ack($sformatf("vec%0d_ack_one_cycle", v));
    end

    // All four held from a fresh pointer: strict rotation, re-requests go last
    do_reset();
    rr_exp = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd0};
    for (int i = 0; i < NUM_REQ; i++) set_slot(i, 8'h20 + 8'(i), 4'd8);
    lo_delay = 1;
    cs_len = 2;
    req = 4'hF;
    for (int k = 0; k < 5; k++) begin
      slave_rdata = 8'h10 + 8'(k);
      wait_ack(100, cyc);
      chk($sformatf("rr%0d_ack", k), 32'(ack), 32'd1 << rr_exp[k]);
      chk($sformatf("rr%0d_rdata", k), 32'(rdata), 32'h10 + 32'(k));
      chk($sformatf("rr%0d_m_data_in", k), 32'(m_data_in), 32'h20 + 32'(rr_exp[k]));
      if (k == 4) req = '0;
      clear_ack($sformatf("rr%0d_ack_one_cycle", k));
    end

    // Silent master: WAIT_LO timeout, TIMEOUT cycles after WAIT_LO entry (cycle 2)
    master_on = 1'b0;
    set_slot(2, 8'h5E, 4'd8);
    req[2] = 1'b1;
    wait_ack(200, cyc);
    chk("tlo_ack", 32'(ack), 32'h4);
    chk("tlo_err", 32'(err), 32'd1);
    chk("tlo_rdata", 32'(rdata), 32'd0);
    chk("tlo_latency", 32'(cyc), 32'(TIMEOUT + 2));
    req[2] = 1'b0;
    clear_ack("tlo_ack_one_cycle");
    master_on = 1'b1;
    lo_delay = 1;
    cs_len = 2;
    slave_rdata = 8'hC9;
    req[2] = 1'b1;
    wait_ack(100, cyc);
    chk("tlo_next_ack", 32'(ack), 32'h4);
    chk("tlo_next_err", 32'(err), 32'd0);
    chk("tlo_next_rdata", 32'(rdata), 32'hC9);
    req[2] = 1'b0;
    clear_ack("tlo_next_ack_one_cycle");

    // cs stuck low: WAIT_HI timeout, WAIT_HI entered at cycle 3
    set_slot(1, 8'h0F, 4'd5);
    cs_len = TIMEOUT + 10;
    dev_low_seen = '0;
    req[1] = 1'b1;
    wait_ack(200, cyc);
    chk("thi_ack", 32'(ack), 32'h2);
    chk("thi_err", 32'(err), 32'd1);
    chk("thi_rdata", 32'(rdata), 32'd0);
    chk("thi_latency", 32'(cyc), 32'(TIMEOUT + 3));
    chk("thi_dev_cs_low", 32'(dev_low_seen), 32'h2);
    req[1] = 1'b0;
    clear_ack("thi_ack_one_cycle");
    wait_master_idle(200);

    // Reset while in WAIT_HI
    set_slot(0, 8'h77, 4'd8);
    lo_delay = 1;
    cs_len = 20;
    req[0] = 1'b1;
    repeat (4) @(negedge sys_clk);
    chk("rwh_busy", 32'(busy), 32'd1);
    chk("rwh_dev_cs_n", 32'(dev_cs_n), 32'hE);
    rst = 1'b0;
    req = '0;
    @(negedge sys_clk);
    check_reset_vals("rwh");
    rst = 1'b1;
    acks_seen = 0;
    repeat (30) begin
      @(negedge sys_clk);
      if (ack != '0) acks_seen++;
    end
    chk("rwh_no_ack", 32'(acks_seen), 32'd0);
    wait_master_idle(50);

    // Requester 3 drops req after grant; pointer must wrap to 0 afterwards
    set_slot(1, 8'h31, 4'd8);
    lo_delay = 1;
    cs_len = 1;
    slave_rdata = 8'h44;
    req[1] = 1'b1;
    wait_ack(100, cyc);
    chk("drop_pre_ack", 32'(ack), 32'h2);
    req[1] = 1'b0;
    clear_ack("drop_pre_ack_one_cycle");
    set_slot(3, 8'h66, 4'd8);
    lo_delay = 2;
    cs_len = 3;
    slave_rdata = 8'h99;
    req[3] = 1'b1;
    @(negedge sys_clk);
    chk("drop_grant_id", 32'(grant_id), 32'd3);
    chk("drop_m_t_begin", 32'(m_t_begin), 32'd1);
    @(negedge sys_clk);
    req[3] = 1'b0;
    set_slot(3, 8'h00, 4'd0);
    wait_ack(100, cyc);
    chk("drop_ack", 32'(ack), 32'h8);
    chk("drop_err", 32'(err), 32'd0);
    chk("drop_rdata", 32'(rdata), 32'h99);
    chk("drop_m_data_in", 32'(m_data_in), 32'h66);
    chk("drop_m_t_size", 32'(m_t_size), 32'd8);
    clear_ack("drop_ack_one_cycle");
    for (int i = 0; i < NUM_REQ; i++) set_slot(i, 8'hA0 + 8'(i), 4'd8);
    cs_len = 1;
    req = 4'hF;
    wait_ack(100, cyc);
    chk("drop_ptr_wrapped", 32'(ack), 32'h1);
    req = '0;
    clear_ack("drop_post_ack_one_cycle");

    // Randomized traffic against the round-robin model
    do_reset();
    model_ptr = 0;
    pend = '0;
    for (int t = 0; t < 60; t++) begin
      new_mask = 4'($urandom_range(0, 15)) & ~pend;
      if (pend == '0 && new_mask == '0) new_mask = 4'b0001 << $urandom_range(0, 3);
      for (int i = 0; i < NUM_REQ; i++) begin
        if (new_mask[i]) begin
          d_arr[i] = 8'($urandom);
          s_arr[i] = 4'($urandom_range(0, 10));
          set_slot(i, d_arr[i], s_arr[i]);
          req[i] = 1'b1;
        end
      end
      pend = pend | new_mask;
      lo_delay = $urandom_range(1, 3);
      cs_len = $urandom_range(1, 6);
      slave_rdata = 8'($urandom);
      exp_id = rr_pick(pend, model_ptr);
      exp_err = (s_arr[exp_id] == 4'd0) || (s_arr[exp_id] > 4'd8);
      wait_ack(200, cyc);
      chk($sformatf("rnd%0d_ack", t), 32'(ack), 32'd1 << exp_id);
      chk($sformatf("rnd%0d_err", t), 32'(err), 32'(exp_err));
      chk($sformatf("rnd%0d_rdata", t), 32'(rdata), exp_err ? 32'd0 : 32'(slave_rdata));
      chk($sformatf("rnd%0d_grant_id", t), 32'(grant_id), 32'(exp_id));
      chk($sformatf("rnd%0d_m_data_in", t), 32'(m_data_in), 32'(d_arr[exp_id]));
      chk($sformatf("rnd%0d_m_t_size", t), 32'(m_t_size), 32'(s_arr[exp_id]));
      model_ptr = (exp_id + 1) % NUM_REQ;
      req[exp_id] = 1'b0;
      pend[exp_id] = 1'b0;
      clear_ack($sformatf("rnd%0d_ack_one_cycle", t));
    end
    req = '0;
    repeat (3) @(negedge sys_clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
